// File: rtl/tea_decrypt_ctrl_pkg.sv
// tea_pkg: shared TEA constants, state encoding and block/key types
// used by the decryption controller, its round function and its interface.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, DONE} tea_state_t;

    // Index 3 is the most significant word, so key[3]=k0 and block[1]=v0.
    typedef logic [3:0][31:0] tea_key_t;
    typedef logic [1:0][31:0] tea_block_t;

    function automatic logic [31:0] init_sum(logic [31:0] delta, int unsigned rounds);
        return 32'(delta * rounds);
    endfunction

endpackage

// File: rtl/tea_decrypt_ctrl_if.sv
// tea_decrypt_ctrl_if: valid/ready block-in and plaintext-out streams of the decryptor.
interface tea_decrypt_ctrl_if;
    import tea_pkg::*;

    logic       in_valid;
    logic       in_ready;
    tea_block_t cipher;
    tea_key_t   key;
    logic       out_valid;
    logic       out_ready;
    tea_block_t plain;
    logic       busy;

    modport master (
        output in_valid, cipher, key, out_ready,
        input  in_ready, out_valid, plain, busy
    );

    modport slave (
        input  in_valid, cipher, key, out_ready,
        output in_ready, out_valid, plain, busy
    );

endinterface

// File: rtl/tea_feistel_f.sv
// tea_feistel_f: combinational TEA round function F(x, ka, kb, sum).
module tea_feistel_f (
    input  logic [31:0] x,
    input  logic [31:0] ka,
    input  logic [31:0] kb,
    input  logic [31:0] sum,
    output logic [31:0] y
);

    assign y = ((x << 4) + ka) ^ (x + sum) ^ ((x >> 5) + kb);

endmodule

// File: rtl/tea_decrypt_ctrl.sv
// tea_decrypt_ctrl: iterative TEA decryptor sharing one round-function instance
// across two half-round cycles per round.
module tea_decrypt_ctrl
    import tea_pkg::*;
#(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input logic               clk,
    input logic               rst,
    tea_decrypt_ctrl_if.slave bus
);

    localparam int          CW   = $clog2(ROUNDS) + 1;
    localparam logic [31:0] SUM0 = init_sum(DELTA, ROUNDS);

    tea_state_t    state, state_nx;
    logic [31:0]   v0, v1, sum;
    logic [31:0]   fx, fa, fb, fy;
    tea_key_t      k;
    logic [CW-1:0] cnt;
    logic          last;

    assign last = cnt == CW'(ROUNDS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        bus.busy      = state != IDLE;
        case (state)
            IDLE:    state_nx = bus.in_valid ? RUN_A : IDLE;
            RUN_A:   state_nx = RUN_B;
            RUN_B:   state_nx = last ? DONE : RUN_A;
            DONE:    state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // RUN_A updates v1 from v0 with (k2,k3); RUN_B updates v0 from v1 with (k0,k1).
    assign fx = state == RUN_B ? v1   : v0;
    assign fa = state == RUN_B ? k[3] : k[1];
    assign fb = state == RUN_B ? k[2] : k[0];

    tea_feistel_f u_f (
        .x  (fx),
        .ka (fa),
        .kb (fb),
        .sum(sum),
        .y  (fy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0  <= '0;
            v1  <= '0;
            sum <= '0;
            cnt <= '0;
            k   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    v0  <= bus.cipher[1];
                    v1  <= bus.cipher[0];
                    k   <= bus.key;
                    sum <= SUM0;
                    cnt <= '0;
                end
                RUN_A: v1 <= v1 - fy;
                RUN_B: begin
                    v0  <= v0 - fy;
                    sum <= sum - DELTA;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.plain = {v0, v1};

endmodule

// File: tb/tb_tea_decrypt_ctrl.sv
// tb_tea_decrypt_ctrl: directed bench for the TEA decryptor with an encrypting
// reference model and an expected-plaintext scoreboard.
module tb_tea_decrypt_ctrl;
    import tea_pkg::*;

    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [63:0] sb[$];

    tea_decrypt_ctrl_if bus ();

    tea_decrypt_ctrl #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fr(logic [31:0] x, logic [31:0] ka, logic [31:0] kb, logic [31:0] s);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    function automatic logic [63:0] encrypt(logic [63:0] p, logic [127:0] k);
        logic [31:0] a, b, s;
        a = p[63:32];
        b = p[31:0];
        s = 32'h0;
        for (int i = 0; i < ROUNDS; i++) begin
            s = s + DELTA;
            a = a + fr(b, k[127:96], k[95:64], s);
            b = b + fr(a, k[63:32], k[31:0], s);
        end
        return {a, b};
    endfunction

    function automatic logic [127:0] rkey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] rblk();
        return {$urandom, $urandom};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(string tag);
        logic [63:0] e;
        e = sb.size() != 0 ? sb.pop_front() : 64'hx;
        check(tag, bus.plain, e);
    endtask

    // Returns at the negedge right after the accepting edge.
    task automatic send(logic [63:0] c, logic [127:0] k);
        int n = 0;
        @(negedge clk);
        bus.cipher   = c;
        bus.key      = k;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_block(string tag, logic [63:0] p, logic [127:0] k);
        int lat;
        sb.push_back(p);
        send(encrypt(p, k), k);
        wait_done(lat);
        check({tag, "_latency"}, lat, 64);
        check({tag, "_sum"}, dut.sum, 0);
        pop_check({tag, "_plain"});
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, bus.out_valid, 0);
    endtask

    initial begin
        logic [63:0]  p, pb, c0, hold;
        logic [127:0] k, kb;
        int lat, cyc, nout;
        int acc[$];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cipher    = '0;
        bus.key       = '0;

        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_plain", bus.plain, 0);
        @(negedge clk);
        rst = 1'b0;

        // Known answer: all-zero key and plaintext.
        sb.push_back(64'h0);
        send(64'h41EA3A0A_94BAA940, 128'h0);
        check("kat_busy", bus.busy, 1);
        wait_done(lat);
        check("kat_latency", lat, 64);
        pop_check("kat_plain");
        @(negedge clk);
        check("kat_valid_one_cycle", bus.out_valid, 0);
        check("kat_idle_ready", bus.in_ready, 1);

        for (int i = 0; i < 20; i++) run_block("rt", rblk(), rkey());

        // Backpressure in DONE with ignored in_valid pulses.
        p = rblk();
        k = rkey();
        bus.out_ready = 1'b0;
        sb.push_back(p);
        send(encrypt(p, k), k);
        wait_done(lat);
        check("bp_latency", lat, 64);
        hold = sb.size() != 0 ? sb[0] : 64'hx;
        for (int i = 0; i < 10; i++) begin
            check("bp_plain", bus.plain, hold);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            bus.in_valid = i[0];
            bus.cipher   = rblk();
            bus.key      = rkey();
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        pop_check("bp_plain_final");
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus.in_ready, 1);
        check("bp_release_valid", bus.out_valid, 0);
        run_block("bp_next", rblk(), rkey());

        // Input changes and in_valid pulses while running are ignored.
        p = rblk();
        k = rkey();
        sb.push_back(p);
        send(encrypt(p, k), k);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~i[0];
            bus.cipher   = rblk();
            bus.key      = rkey();
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_done(lat);
        check("ign_latency", lat + 10, 64);
        pop_check("ign_plain");
        @(negedge clk);

        // Reset during half-round 17.
        p = rblk();
        k = rkey();
        sb.push_back(p);
        send(encrypt(p, k), k);
        repeat (16) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        run_block("after_rst", rblk(), rkey());

        // Reset while holding a finished result drops out_valid without a clock edge.
        bus.out_ready = 1'b0;
        p = rblk();
        k = rkey();
        send(encrypt(p, k), k);
        wait_done(lat);
        check("donerst_pre_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("donerst_out_valid", bus.out_valid, 0);
        check("donerst_plain", bus.plain, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Back-to-back with in_valid held high.
        p  = rblk();
        k  = rkey();
        pb = rblk();
        kb = rkey();
        c0 = encrypt(p, k);
        @(negedge clk);
        bus.cipher   = c0;
        bus.key      = k;
        bus.in_valid = 1'b1;
        cyc  = 0;
        nout = 0;
        while (nout < 2 && cyc < 400) begin
            if (bus.out_valid && bus.out_ready) begin
                pop_check("b2b_plain");
                nout++;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc.push_back(cyc);
                sb.push_back(acc.size() == 1 ? p : pb);
            end
            @(negedge clk);
            cyc++;
            if (acc.size() == 1 && bus.cipher == c0) begin
                bus.cipher = encrypt(pb, kb);
                bus.key    = kb;
            end
            if (acc.size() == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        check("b2b_outputs", nout, 2);
        check("b2b_spacing", acc.size() == 2 ? acc[1] - acc[0] : -1, 66);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/tea_decrypt_ctrl.md
# tea_decrypt_ctrl

Iterative TEA decryption engine that sequences one shared Feistel round-function instance over 2×ROUNDS half-round cycles to turn a 64-bit ciphertext block into plaintext under a 128-bit key. It sits between the block-input stream and the plaintext output stream of the decryptor. Upstream and downstream both use a valid/ready handshake. It owns all round state, the running `sum`, and key-half selection.

## Interface
Parameters:
- `ROUNDS`, 32: full TEA rounds; each round takes two half-round cycles.
- `DELTA`, 32'h9E3779B9: key-schedule constant.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `cipher`/`key` valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `cipher`  in  64  ciphertext; [63:32]=v0, [31:0]=v1.
- `key`  in  128  k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
- `out_valid`  out  1  `plain` valid.
- `out_ready`  in  1  downstream accepts `plain`.
- `plain`  out  64  plaintext; [63:32]=v0, [31:0]=v1.
- `busy`  out  1  high in RUN_A, RUN_B or DONE.

## Operation
- FSM states: IDLE, RUN_A, RUN_B, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - latch v0, v1 and k0..k3;
  - set `sum` = DELTA×ROUNDS mod 2^32 (0xC6EF3720 for defaults);
  - clear the round counter;
  - go to RUN_A.
- RUN_A: v1 ← v1 − F(v0, k2, k3, sum); go to RUN_B.
- RUN_B: v0 ← v0 − F(v1, k0, k1, sum); sum ← sum − DELTA; counter++.
  - If counter was ROUNDS−1, go to DONE; otherwise go to RUN_A.
- DONE: `out_valid`=1, `plain`={v0,v1}.
  - On `out_ready`, go to IDLE.
  - No input is accepted in the same cycle.
- Round function: F(x, ka, kb, s) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb).
  - Shifts are logical.
  - All additions, subtractions and the `sum` update are modulo 2^32; carries are discarded.
- The single F instance has its operand muxed by state: x=v0, (ka,kb)=(k2,k3) in RUN_A; x=v1, (ka,kb)=(k0,k1) in RUN_B.
- Round counter width is $clog2(ROUNDS)+1.
- `in_valid` outside IDLE is ignored. Latched key/data are not affected by input changes while busy.
- `plain` is stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE;
  - `in_ready`=1;
  - `out_valid`=0, `busy`=0;
  - `plain`=0, v0=v1=0, `sum`=0, counter=0, keys=0.
- Latency: accept edge E. Half-rounds execute on edges E+1..E+2·ROUNDS. `out_valid` is high from the cycle after edge E+2·ROUNDS, i.e. 64 edges after acceptance for the defaults.
- Throughput with `out_ready` tied high: one block per 2·ROUNDS+2 cycles (66 for the defaults).
- `in_ready` and `out_valid` are registered state decodes with no combinational path from `in_valid`/`out_ready`.
- Reset asserted mid-operation: state is abandoned immediately and `out_valid` drops asynchronously. The block is ready in IDLE on the first edge after deassertion.
- F is combinational within one cycle, so the critical path is F followed by a 32-bit subtractor.

## Structure
- Shared package `tea_pkg`:
  - `TEA_DELTA` constant;
  - state enum (IDLE, RUN_A, RUN_B, DONE);
  - `tea_key_t` (4×32) and `tea_block_t` (2×32) typedefs;
  - function computing initial sum = DELTA×ROUNDS.
- Sub-module `tea_feistel_f`: purely combinational F (inputs x, ka, kb, sum; output 32-bit), instantiated once.
- The controller holds the FSM, v0/v1/sum/key registers and the operand muxes.

## Test plan
- Known-answer: key=0, cipher=64'h41EA3A0A_94BAA940, `out_ready`=1 → `plain`=64'h0 with `out_valid` rising exactly 64 edges after accept, held 1 cycle.
- Round-trip: 20 random key/plaintext pairs encrypted by a reference model → decrypted `plain` equals the original; `sum` equals 0 at DONE.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `plain` constant, `in_ready`=0, and `in_valid` pulses are ignored; release → IDLE the next cycle, next accept proceeds.
- Ignored input: change `cipher`/`key` and pulse `in_valid` during RUN_A/RUN_B → result unchanged versus the undisturbed run.
- Reset mid-run: assert `rst` at half-round 17 → `out_valid`=0, `busy`=0 immediately; a subsequent block decrypts correctly with full 64-cycle latency.
- Back-to-back: two blocks with `in_valid` held high and `out_ready`=1 → second accept 66 cycles after the first, both outputs correct.
